// File: rtl/ashleyjr_delay_line.sv
// Programmable delay line: an 8-bit sample shifts through DEPTH stages on
// every enabled clock, and a loadable tap selects which stage drives uo_out.
// A saturating fill counter reports when the selected tap holds real samples
// captured since the last reset.
module ashleyjr_delay_line #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] ui_in,
   output logic [WIDTH-1:0] uo_out,
   input  logic [7:0]       uio_in,
   output logic [7:0]       uio_out,
   output logic [7:0]       uio_oe
);

   localparam int TAP_W  = $clog2(DEPTH);
   localparam int FILL_W = TAP_W + 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

   logic [WIDTH-1:0]  stage [DEPTH];
   logic [TAP_W-1:0]  tap;
   logic [FILL_W-1:0] fill;
   logic              valid;
   logic              unused_bits;

   // Shift register: newest sample in stage[0], oldest falls off the end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else if (ena) begin
         stage[0] <= ui_in;
         for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
   end

   // Tap register, loaded on the same edge as that cycle's shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap <= '0;
      end else if (ena && uio_in[6]) begin
         tap <= uio_in[TAP_W-1:0];
      end
   end

   // Fill counter: counts enabled edges since reset, saturating at DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill <= '0;
      end else if (ena && (fill != FILL_MAX)) begin
         fill <= fill + 1'b1;
      end
   end

   // Output mux and status: purely from registers, no path from the inputs
   always_comb begin
      uo_out  = stage[tap];
      valid   = (fill > {1'b0, tap});
      uio_out = {valid, 7'b0};
      uio_oe  = 8'b1000_0000;
   end

   // uio_in[7] carries no function
   assign unused_bits = &{1'b0, uio_in[7]};

endmodule

// File: tb/tb_ashleyjr_delay_line.sv
// Self-checking bench for ashleyjr_delay_line. The reference keeps every
// sample captured since reset in a queue; the expected output is simply the
// sample captured D enabled edges ago, and valid means that sample exists.
module tb_ashleyjr_delay_line;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference state
   logic [7:0] hist[$];
   int         m_d;

   ashleyjr_delay_line #(.DEPTH(64), .WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] exp_uo();
      if (hist.size() > m_d) return hist[hist.size() - 1 - m_d];
      return 8'h00;
   endfunction

   function automatic logic exp_valid();
      int f;
      f = (hist.size() > 64) ? 64 : hist.size();
      return (f > m_d);
   endfunction

   // One clock: drive inputs, take the edge, update the reference, settle
   task automatic step(input logic [7:0] d, input logic ld, input logic [5:0] tp,
                       input logic en);
      ui_in  = d;
      uio_in = {1'($urandom), ld, tp};
      ena    = en;
      @(posedge clk);
      if (en) begin
         hist.push_back(d);
         if (ld) m_d = tp;
      end
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #3 rst = 1'b0;
      hist.delete();
      m_d = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b0; ui_in = 8'hFF; uio_in = 8'hFF;
      hist.delete(); m_d = 0;
      #12;
      n_cmp++;
      if (uo_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_uo: got %h want 00", uo_out);
      end
      n_cmp++;
      if (uio_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_uio_out: got %h want 00", uio_out);
      end
      n_cmp++;
      if (uio_oe !== 8'h80) begin
         n_fail++; $display("FAIL reset_uio_oe: got %h want 80", uio_oe);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_d0();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(vals[i], 1'b0, 6'd0, 1'b1);
         n_cmp++;
         if (uo_out !== vals[i]) begin
            n_fail++; $display("FAIL d0_uo[%0d]: got %h want %h", i, uo_out, vals[i]);
         end
         n_cmp++;
         if (uio_out !== 8'h80) begin
            n_fail++; $display("FAIL d0_valid[%0d]: got %h want 80", i, uio_out);
         end
      end
   endtask

   task automatic test_d5();
      logic [7:0] want;
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         step(8'(e), (e == 1), 6'd5, 1'b1);
         want = (e > 5) ? 8'(e - 5) : 8'h00;
         n_cmp++;
         if (uo_out !== want || uo_out !== exp_uo()) begin
            n_fail++; $display("FAIL d5_uo edge %0d: got %h want %h", e, uo_out, want);
         end
         n_cmp++;
         if (uio_out[7] !== (e >= 6) || uio_out[6:0] !== 7'd0) begin
            n_fail++; $display("FAIL d5_valid edge %0d: got %h want %0d", e, uio_out, e >= 6);
         end
         n_cmp++;
         if (uio_oe !== 8'h80) begin
            n_fail++; $display("FAIL d5_oe edge %0d: got %h want 80", e, uio_oe);
         end
      end
   endtask

   task automatic test_d63();
      logic [7:0] want;
      do_reset();
      for (int e = 1; e <= 128; e++) begin
         step(8'(e - 1), (e == 1), 6'd63, 1'b1);
         want = (e >= 64) ? 8'(e - 64) : 8'h00;
         n_cmp++;
         if (uo_out !== want || uo_out !== exp_uo()) begin
            n_fail++; $display("FAIL d63_uo edge %0d: got %h want %h", e, uo_out, want);
         end
         n_cmp++;
         if (uio_out[7] !== (e >= 64)) begin
            n_fail++; $display("FAIL d63_valid edge %0d: got %b want %0d", e, uio_out[7], e >= 64);
         end
      end
   endtask

   task automatic test_tap_change();
      do_reset();
      for (int i = 1; i <= 70; i++) begin
         step(8'(i), (i == 1), 6'd10, 1'b1);
         n_cmp++;
         if (uo_out !== exp_uo() || uio_out[7] !== exp_valid()) begin
            n_fail++;
            $display("FAIL tap_fill edge %0d: got %h/%b want %h/%b", i, uo_out, uio_out[7],
                     exp_uo(), exp_valid());
         end
      end
      step(8'd71, 1'b1, 6'd2, 1'b1);
      n_cmp++;
      if (uo_out !== 8'd69 || uio_out[7] !== 1'b1) begin
         n_fail++; $display("FAIL tap_to2: got %h/%b want 45/1", uo_out, uio_out[7]);
      end
      step(8'd72, 1'b1, 6'd10, 1'b1);
      n_cmp++;
      if (uo_out !== 8'd62 || uio_out[7] !== 1'b1) begin
         n_fail++; $display("FAIL tap_to10: got %h/%b want 3e/1", uo_out, uio_out[7]);
      end
   endtask

   task automatic test_ena_freeze();
      logic [7:0] rec_uo, rec_uio;
      do_reset();
      step(8'hA1, 1'b1, 6'd8, 1'b1);
      step(8'hA2, 1'b0, 6'd0, 1'b1);
      step(8'hA3, 1'b0, 6'd0, 1'b1);
      rec_uo = uo_out; rec_uio = uio_out;
      for (int i = 0; i < 20; i++) begin
         step(8'($urandom), (i == 7), 6'd0, 1'b0);
         n_cmp++;
         if (uo_out !== rec_uo || uio_out !== rec_uio) begin
            n_fail++;
            $display("FAIL freeze[%0d]: got %h/%h want %h/%h", i, uo_out, uio_out, rec_uo, rec_uio);
         end
      end
      for (int k = 1; k <= 10; k++) begin
         step(8'(8'hB0 + k), 1'b0, 6'd0, 1'b1);
         n_cmp++;
         if (uio_out[7] !== (k >= 6) || uo_out !== exp_uo()) begin
            n_fail++;
            $display("FAIL resume[%0d]: got %h/%b want %h/%0d", k, uo_out, uio_out[7],
                     exp_uo(), k >= 6);
         end
      end
      n_cmp++;
      if (uo_out !== 8'hB2) begin
         n_fail++; $display("FAIL resume_data: got %h want b2", uo_out);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 1; i <= 70; i++) step(8'(i), (i == 1), 6'd20, 1'b1);
      n_cmp++;
      if (uo_out !== 8'd50 || uio_out[7] !== 1'b1) begin
         n_fail++; $display("FAIL areset_pre: got %h/%b want 32/1", uo_out, uio_out[7]);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         n_fail++; $display("FAIL areset_now: got %h/%h want 00/00", uo_out, uio_out);
      end
      #2 rst = 1'b0;
      hist.delete(); m_d = 0;
      step(8'h5A, 1'b0, 6'd0, 1'b1);
      n_cmp++;
      if (uo_out !== 8'h5A || uio_out !== 8'h80) begin
         n_fail++; $display("FAIL areset_refill: got %h/%h want 5a/80", uo_out, uio_out);
      end
   endtask

   task automatic test_random();
      logic en, ld;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 15) == 0);
         step(8'($urandom), ld, 6'($urandom), en);
         n_cmp++;
         if (uo_out !== exp_uo() || uio_out !== {exp_valid(), 7'd0}) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h/%h want %h/%h", i, uo_out, uio_out,
                     exp_uo(), {exp_valid(), 7'd0});
         end
      end
   endtask

   initial begin
      test_reset();
      test_d0();
      test_d5();
      test_d63();
      test_tap_change();
      test_ena_freeze();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ashleyjr_delay_line.md
Name: ashleyjr_delay_line

Overview:
- Programmable digital delay line for the TinyTapeout user slot.
- Each enabled clock, an 8-bit sample on ui_in enters a 64-stage shift register.
- uo_out presents the sample from a selectable tap, giving a delay of 1 to 64 clocks.
- A status pin indicates when the selected tap holds valid, post-reset data.

Parameters:
- DEPTH, 64, number of shift stages; the tap index is log2(DEPTH) = 6 bits wide.
- WIDTH, 8, sample width in bits.

Ports:
- clk  input  1  Single clock, rising edge.
- rst  input  1  Asynchronous reset, active-high. The top-level pin wrapper drives it from !rst_n.
- ena  input  1  Global enable. When low, all state is frozen.
- ui_in  input  8  Data sample entering the line.
- uo_out  output  8  Delayed sample from the selected tap.
- uio_in  input  8  [5:0] tap value D_in. [6] load strobe. [7] unused.
- uio_out  output  8  [7] valid flag. [6:0] driven 0.
- uio_oe  output  8  Constant 8'b1000_0000. Only bit 7 is an output.

Behaviour:
- Reset, asynchronous on rst high:
  - All stages s[0..63] cleared to 0.
  - Tap register D cleared to 0.
  - Fill counter F cleared to 0.
  - Therefore uo_out = 0 and uio_out = 0 immediately.
  - Reset asserted mid-operation discards all history.
- Shift, on each rising edge with ena = 1:
  - s[0] <= ui_in.
  - s[k] <= s[k-1] for k = 1..63.
  - The oldest sample is dropped.
- Tap load, on a rising edge with ena = 1 and uio_in[6] = 1:
  - D <= uio_in[5:0].
  - The load occurs on the same edge as that cycle's shift.
- Output path:
  - uo_out = s[D], a combinational mux from flops only; no combinational path from ui_in or uio_in.
  - With D constant, uo_out after edge t equals the ui_in sampled at edge t-D. Latency is D+1 enabled clocks relative to the capture edge.
  - D = 0 gives one-clock latency; D = 63 gives 64-clock latency.
- Tap change: the output switches to the new tap in the cycle after the load edge. The line is not flushed; existing history is shown immediately.
- Fill counter F:
  - 7 bits, incremented on every enabled edge.
  - Saturates at 64; it never wraps.
- Valid flag: uio_out[7] = (F > D), combinational from registers.
  - After reset, valid rises on the (D+1)-th enabled edge.
  - Reducing D can set valid immediately. Increasing D can clear it until F catches up.
  - Once F = 64, valid stays 1 for any D.
- ena = 0:
  - No shift, no tap load, F holds.
  - uo_out and uio_out hold their values.
  - Asynchronous reset still applies.
- Simultaneous load and shift: the shift uses the old state. The new D is applied to the post-edge stage contents.
- uio_in[7] is ignored.
- All unused output bits are driven to 0.

Test Plan:
- Reset then D=0: apply ui_in = 0x11, 0x22, 0x33 on successive edges -> uo_out = 0x11, 0x22, 0x33, each one clock after capture. uio_out[7] = 1 after the first edge.
- Load D=5 (uio_in = 0x45 for one edge) after reset, then stream ui_in = 1, 2, 3, ... -> uo_out shows sample n on edge n+5. uio_out[7] rises on the 6th enabled edge. uio_oe stays 0x80.
- D=63: stream 0x00..0x7F -> the first nonzero output, 0x01, appears 63 edges after its capture. Valid rises exactly at the 64th edge. F saturates and valid stays 1 thereafter.
- Tap change on the fly: D=10, line full of ramp data. Load D=2 -> next cycle uo_out = the sample captured 2 edges prior. Reload D=10 -> the old history reappears with no flush.
- ena low for 20 cycles mid-stream with ui_in toggling -> uo_out, uio_out and F frozen. A uio_in[6] pulse during this time does not change D. Resuming continues exactly where the line stopped.
- Assert rst asynchronously between edges with the line full -> uo_out = 0x00 and uio_out[7] = 0 immediately. After release, D = 0 and refilling starts from empty.
